// File: rtl/eq_check_arbiter_pkg.sv
// Shared types and default sizes for the two-requester equality checker.
// Holds the one-bit arbiter priority state and the default widths.
package eq_check_arbiter_pkg;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;

  localparam int DEF_W     = 1;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/eq_sat_counter.sv
// Saturating up-counter with synchronous clear; updates one cycle after inc/clr.
// No backpressure: an increment at full scale is silently dropped, clr wins over inc.
module eq_sat_counter
  import eq_check_arbiter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/eq_check_arbiter.sv
// Round-robin arbiter for two operand-pair requesters feeding one equality checker; result latency 1.
// One pair accepted per cycle via combinational ready; results and counters are never backpressured.
module eq_check_arbiter
  import eq_check_arbiter_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             req1_ready,
  input  logic             clr,
  output logic             res_valid,
  output logic             res_id,
  output logic             res_eq,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky
);

  arb_state_t state, state_nxt;
  logic       gnt0, gnt1;
  logic       res_valid_q, res_id_q, res_eq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRI0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (gnt0) begin
      state_nxt = PRI1;
    end else if (gnt1) begin
      state_nxt = PRI0;
    end
  end

  // A lone requester wins regardless of priority; a tie goes to the priority holder.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = req0_valid && (!req1_valid || (state == PRI0));
      gnt1 = req1_valid && (!req0_valid || (state == PRI1));
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_eq_q    <= 1'b0;
    end else begin
      res_valid_q <= gnt0 || gnt1;
      if (gnt0) begin
        res_id_q <= 1'b0;
        res_eq_q <= (req0_a == req0_b);
      end else if (gnt1) begin
        res_id_q <= 1'b1;
        res_eq_q <= (req1_a == req1_b);
      end
    end
  end

  // Masking with rst drops a result that is in flight when reset arrives.
  assign res_valid = res_valid_q & ~rst;
  assign res_id    = res_id_q    & ~rst;
  assign res_eq    = res_eq_q    & ~rst;

  eq_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (res_valid_q && res_eq_q),
    .cnt (pass_cnt)
  );

  eq_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (res_valid_q && !res_eq_q),
    .cnt (fail_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_sticky <= 1'b0;
    end else if (res_valid_q && !res_eq_q) begin
      err_sticky <= 1'b1;
    end
  end

endmodule
